// File: rtl/text_ram_loader.sv
// text_ram_loader
// Owns the TextRAM program-memory port. It streams a program image from a
// byte source into TextRAM with setup/strobe/hold write cycles, then hands
// the port to the MC14500B fetch logic. The CPU is stalled whenever the
// loader owns the RAM.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   load_start/len   start a load of load_len words (accepted in IDLE/RUN)
//   run_start        IDLE -> RUN without loading
//   rx_valid/ready   byte-source handshake, rx_data is the word to store
//   cpu_address      CPU fetch address, cpu_data is the fetched word
//   cpu_stall        CPU must hold its state
//   ram_*            TextRAM write strobe, address, write data, read data
//   load_done        one-cycle pulse after the last word's HOLD
//   load_error       sticky, set for an oversized load_len
module text_ram_loader #(
  parameter int WORD     = 8,
  parameter int SIZE_LOG = 8,
  parameter int SIZE     = 2 ** SIZE_LOG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic [SIZE_LOG:0]   load_len,
  input  logic                run_start,
  input  logic                rx_valid,
  input  logic [WORD-1:0]     rx_data,
  output logic                rx_ready,
  input  logic [SIZE_LOG-1:0] cpu_address,
  output logic [WORD-1:0]     cpu_data,
  output logic                cpu_stall,
  output logic                ram_write,
  output logic [SIZE_LOG-1:0] ram_address,
  output logic [WORD-1:0]     ram_data_in,
  input  logic [WORD-1:0]     ram_data_out,
  output logic                load_done,
  output logic                load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RUN
  } state_t;

  localparam logic [SIZE_LOG:0] LP_SIZE = (SIZE_LOG + 1)'(SIZE);

  state_t                r_state;
  logic [SIZE_LOG:0]     r_count;
  logic [SIZE_LOG:0]     r_len;
  logic [SIZE_LOG-1:0]   r_addr;
  logic [WORD-1:0]       r_data;
  logic                  r_rx_ready;
  logic                  r_stall;
  logic                  r_write;
  logic                  r_done;
  logic                  r_error;

  logic                  w_cpu_owns;
  logic [SIZE_LOG:0]     w_count_inc;

  assign w_cpu_owns  = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_count_inc = r_count + 1'b1;

  // The CPU address goes straight through so a fetch sees no extra latency;
  // during a load the registered address keeps the port stable.
  assign ram_address = w_cpu_owns ? cpu_address : r_addr;
  // Write data always comes from the register, never from rx_data, so it
  // cannot glitch while the strobe is high.
  assign ram_data_in = r_data;
  assign cpu_data    = ram_data_out;
  assign ram_write   = r_write;
  assign rx_ready    = r_rx_ready;
  assign cpu_stall   = r_stall;
  assign load_done   = r_done;
  assign load_error  = r_error;

  // NOTE: every register here is sequential state and uses <=, so all
  // right-hand sides see the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rx_ready <= 1'b0;
      r_stall    <= 1'b1;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      // load_done is a single-cycle pulse; only HOLD or a zero-length load
      // raise it again.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN: begin
          if (load_start) begin
            r_error <= 1'b0;
            if (load_len == '0) begin
              r_done  <= 1'b1;
              r_stall <= 1'b0;
              r_state <= S_RUN;
            end else if (load_len > LP_SIZE) begin
              r_error <= 1'b1;
              r_stall <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_count    <= '0;
              r_len      <= load_len;
              r_stall    <= 1'b1;
              r_rx_ready <= 1'b1;
              r_state    <= S_WAIT_WORD;
            end
          end else if (run_start && (r_state == S_IDLE)) begin
            r_stall <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_WAIT_WORD: begin
          if (rx_valid && r_rx_ready) begin
            r_data     <= rx_data;
            r_addr     <= r_count[SIZE_LOG-1:0];
            r_rx_ready <= 1'b0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_write <= 1'b1;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          r_write <= 1'b0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_count <= w_count_inc;
          if (w_count_inc == r_len) begin
            r_done  <= 1'b1;
            r_stall <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_rx_ready <= 1'b1;
            r_state    <= S_WAIT_WORD;
          end
        end
        default: begin
          r_write    <= 1'b0;
          r_rx_ready <= 1'b0;
          r_stall    <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_ram_loader.sv
// Self-checking bench for text_ram_loader: a behavioural TextRAM, an
// expected-image array, a write scoreboard and a strobe-timing monitor.
module tb_text_ram_loader;

  localparam int WORD     = 8;
  localparam int SIZE_LOG = 8;
  localparam int SIZE     = 256;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                load_start = 1'b0;
  logic [SIZE_LOG:0]   load_len = '0;
  logic                run_start = 1'b0;
  logic                rx_valid = 1'b0;
  logic [WORD-1:0]     rx_data = '0;
  logic                rx_ready;
  logic [SIZE_LOG-1:0] cpu_address = '0;
  logic [WORD-1:0]     cpu_data;
  logic                cpu_stall;
  logic                ram_write;
  logic [SIZE_LOG-1:0] ram_address;
  logic [WORD-1:0]     ram_data_in;
  logic [WORD-1:0]     ram_data_out;
  logic                load_done;
  logic                load_error;

  text_ram_loader #(.WORD(WORD), .SIZE_LOG(SIZE_LOG), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_len(load_len), .run_start(run_start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_stall(cpu_stall),
    .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Behavioural TextRAM: captures on the rising edge of the write strobe.
  logic [WORD-1:0] ram [SIZE];
  always @(posedge ram_write) ram[ram_address] <= ram_data_in;
  assign ram_data_out = ram[ram_address];

  logic [WORD-1:0] exp_mem [SIZE];
  logic [WORD-1:0] img [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: write scoreboard, load_done counter and strobe timing.
  typedef struct { logic w; logic rst; logic [SIZE_LOG-1:0] a; logic [WORD-1:0] d; } samp_t;
  typedef struct { logic [SIZE_LOG-1:0] a; logic [WORD-1:0] d; } wr_t;
  samp_t s0, s1, sc;
  wr_t   wq [$];
  int    write_cnt = 0;
  int    done_cnt  = 0;

  initial begin
    s0 = '{1'b0, 1'b0, '0, '0};
    s1 = '{1'b0, 1'b0, '0, '0};
  end

  always @(negedge clk) begin
    sc = '{ram_write, reset, ram_address, ram_data_in};
    if (s1.w && !s1.rst) begin
      check("setup_addr", {24'd0, s0.a}, {24'd0, s1.a});
      check("setup_data", {24'd0, s0.d}, {24'd0, s1.d});
      check("hold_addr",  {24'd0, sc.a}, {24'd0, s1.a});
      check("hold_data",  {24'd0, sc.d}, {24'd0, s1.d});
    end
    if (sc.w) begin
      write_cnt++;
      wq.push_back('{sc.a, sc.d});
    end
    if (load_done) done_cnt++;
    s0 = s1;
    s1 = sc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load_start = 1'b0; run_start = 1'b0; rx_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_load(input int len);
    load_start = 1'b1;
    load_len   = (SIZE_LOG + 1)'(len);
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD-1:0] d, input int gap, output int acc);
    bit got = 0;
    acc = -1;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = d;
    for (int i = 0; i < 64 && !got; i++) begin
      if (rx_ready) begin
        acc = cyc;
        got = 1;
      end
      tick();
    end
    rx_valid = 1'b0;
    if (!got) check("rx_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(output int at);
    bit got = 0;
    at = -1;
    for (int i = 0; i < 32 && !got; i++) begin
      if (load_done) begin
        at  = cyc;
        got = 1;
      end else begin
        tick();
      end
    end
    if (!got) check("load_done_timeout", 0, 1);
  endtask

  // Full load of img[] with random rx gaps, then image and readback checks.
  task automatic run_load(input int maxgap, output int first_acc, output int done_at);
    int len;
    int acc;
    len = img.size();
    wq.delete(); write_cnt = 0; done_cnt = 0;
    pulse_load(len);
    check("stall_after_load_start", cpu_stall, 1);
    for (int i = 0; i < len; i++) begin
      send_word(img[i], $urandom_range(0, maxgap), acc);
      if (i == 0) first_acc = acc;
      exp_mem[i] = img[i];
    end
    wait_done(done_at);
    tick();
    check("load_done_once", done_cnt, 1);
    check("load_done_pulse_ends", load_done, 0);
    check("stall_in_run", cpu_stall, 0);
    check("write_count", write_cnt, len);
    if (wq.size() == len) begin
      for (int i = 0; i < len; i++) begin
        check("wr_addr", {24'd0, wq[i].a}, i);
        check("wr_data", {24'd0, wq[i].d}, {24'd0, img[i]});
      end
    end
    for (int i = 0; i < len; i++) begin
      cpu_address = SIZE_LOG'(i);
      #1;
      check("readback", {24'd0, cpu_data}, {24'd0, exp_mem[i]});
    end
  endtask

  // One-step reactions from IDLE.
  typedef struct {
    int len; bit ld; bit rs;
    bit e_done; bit e_err; bit e_stall; bit e_rdy;
  } vec_t;

  initial begin
    vec_t vt [7];
    int acc, dn, t;

    foreach (ram[i]) begin
      ram[i] = '0;
      exp_mem[i] = '0;
    end
    vt[0] = '{0,   1, 0, 1, 0, 0, 0};
    vt[1] = '{257, 1, 0, 0, 1, 1, 0};
    vt[2] = '{511, 1, 0, 0, 1, 1, 0};
    vt[3] = '{1,   1, 0, 0, 0, 1, 1};
    vt[4] = '{256, 1, 0, 0, 0, 1, 1};
    vt[5] = '{0,   0, 1, 0, 0, 0, 0};
    vt[6] = '{5,   1, 1, 0, 0, 1, 1};

    // Reset state.
    cpu_address = 8'h37;
    tick();
    check("rst_ram_write", ram_write, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_cpu_stall", cpu_stall, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_data_in", {24'd0, ram_data_in}, 0);
    check("rst_idle_addr", {24'd0, ram_address}, 32'h37);
    reset = 1'b0;

    // Table: single-cycle reaction to load_start / run_start from IDLE.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      load_start = vt[i].ld;
      run_start  = vt[i].rs;
      load_len   = (SIZE_LOG + 1)'(vt[i].len);
      tick();
      load_start = 1'b0;
      run_start  = 1'b0;
      check($sformatf("tbl%0d_done", i), load_done, vt[i].e_done);
      check($sformatf("tbl%0d_err", i), load_error, vt[i].e_err);
      check($sformatf("tbl%0d_stall", i), cpu_stall, vt[i].e_stall);
      check($sformatf("tbl%0d_rdy", i), rx_ready, vt[i].e_rdy);
      check($sformatf("tbl%0d_write", i), ram_write, 0);
    end

    // Three back-to-back words; load_done 12 cycles after first accept.
    do_reset();
    img = '{8'hA1, 8'hB2, 8'hC3};
    run_load(0, acc, dn);
    check("done_latency", dn - acc, 12);
    cpu_address = 8'd1;
    #1;
    check("fetch_b2", {24'd0, cpu_data}, 32'hB2);

    // run_start from IDLE: RUN next cycle, memory untouched.
    do_reset();
    write_cnt = 0;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("run_start_stall", cpu_stall, 0);
    cpu_address = 8'd2;
    #1;
    check("untouched_c3", {24'd0, cpu_data}, 32'hC3);
    tick();
    check("run_start_no_write", write_cnt, 0);

    // load_len = 0, then run_start (ignored in RUN).
    do_reset();
    pulse_load(0);
    check("len0_done", load_done, 1);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("len0_done_ends", load_done, 0);
    check("len0_run", cpu_stall, 0);

    // Oversized length, then recovery with len = 1.
    do_reset();
    write_cnt = 0;
    cpu_address = 8'h21;
    pulse_load(SIZE + 1);
    tick(); tick();
    check("err_set", load_error, 1);
    check("err_stall", cpu_stall, 1);
    check("err_idle_addr", {24'd0, ram_address}, 32'h21);
    check("err_no_write", write_cnt, 0);
    img = '{8'h5A};
    run_load(2, acc, dn);
    check("err_cleared", load_error, 0);
    pulse_load(300);
    check("err_from_run", load_error, 1);
    check("err_from_run_stall", cpu_stall, 1);

    // rx_valid low for 5 cycles between words.
    do_reset();
    img = {};
    for (int i = 0; i < 4; i++) img.push_back(WORD'($urandom));
    wq.delete(); write_cnt = 0;
    pulse_load(4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        t = 0;
        while (!rx_ready && t < 16) begin tick(); t++; end
        for (int g = 0; g < 5; g++) begin
          check("gap_wait_rdy", rx_ready, 1);
          check("gap_no_write", ram_write, 0);
          tick();
        end
      end
      send_word(img[i], 0, acc);
      exp_mem[i] = img[i];
    end
    wait_done(dn);
    tick();
    check("gap_writes", write_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      cpu_address = SIZE_LOG'(i);
      #1;
      check("gap_readback", {24'd0, cpu_data}, {24'd0, exp_mem[i]});
    end

    // Reset in the STROBE cycle of word 2 of 4.
    do_reset();
    cpu_address = 8'h55;
    pulse_load(4);
    send_word(8'h11, 0, acc);
    send_word(8'h22, 0, acc);
    tick();
    check("strobe_reached", ram_write, 1);
    reset = 1'b1;
    tick();
    check("rst_mid_write", ram_write, 0);
    check("rst_mid_stall", cpu_stall, 1);
    check("rst_mid_rdy", rx_ready, 0);
    check("rst_mid_idle_addr", {24'd0, ram_address}, 32'h55);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_mem[i] = ram[i];

    // Reload from RUN.
    do_reset();
    img = '{8'h3C, 8'h4D, 8'h5E};
    run_load(1, acc, dn);
    img = '{8'h6F, 8'h70};
    run_load(1, acc, dn);
    cpu_address = 8'd2;
    #1;
    check("reload_keeps_old", {24'd0, cpu_data}, 32'h5E);

    // Random loads from RUN.
    for (int n = 0; n < 6; n++) begin
      img = {};
      for (int i = 0; i < $urandom_range(1, 16); i++) img.push_back(WORD'($urandom));
      run_load(3, acc, dn);
    end

    // len == SIZE writes every location without wrapping.
    img = {};
    for (int i = 0; i < SIZE; i++) img.push_back(WORD'($urandom));
    run_load(0, acc, dn);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_ram_loader.md
Name: text_ram_loader

Overview:
- Sequencer and owner of the TextRAM program-memory port.
- Streams a program image from a byte source into TextRAM using correctly timed setup/strobe/hold write cycles, then hands the read port to the MC14500B fetch logic.
- Stalls the CPU whenever the loader owns the RAM.
- Sits between the host/UART receive path, the CPU program counter and the TextRAM instance.

Parameters:
- WORD, 8, TextRAM word width; rx_data is truncated or zero-extended to this width.
- SIZE_LOG, 8, TextRAM address width.
- SIZE, 2**SIZE_LOG, TextRAM depth in words.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse; begins a load of load_len words, sampled in IDLE or RUN only.
- load_len  input  SIZE_LOG+1  number of words to load, sampled with load_start.
- run_start  input  1  one-cycle pulse; IDLE -> RUN without loading.
- rx_valid  input  1  source has a word on rx_data.
- rx_data  input  WORD  word to write.
- rx_ready  output  1  loader accepts rx_data this cycle.
- cpu_address  input  SIZE_LOG  CPU fetch address.
- cpu_data  output  WORD  fetched word; equals ram_data_out.
- cpu_stall  output  1  CPU must hold its state.
- ram_write  output  1  TextRAM write strobe.
- ram_address  output  SIZE_LOG  TextRAM address.
- ram_data_in  output  WORD  TextRAM write data.
- ram_data_out  input  WORD  TextRAM read data.
- load_done  output  1  one-cycle pulse when the last word's HOLD completes.
- load_error  output  1  sticky; set when load_len > SIZE, cleared by the next accepted load_start or by reset.

Behaviour:
- Reset values and reset mid-operation:
  - Synchronous reset puts the FSM in IDLE.
  - Word counter and registered address/data are cleared to 0.
  - ram_write=0, rx_ready=0, cpu_stall=1, load_done=0, load_error=0.
  - Reset during any load state drops ram_write on the same clock edge. The partially written word is not guaranteed.
- States: IDLE, WAIT_WORD, SETUP, STROBE, HOLD, RUN.
- IDLE:
  - cpu_stall=1; ram_address=cpu_address.
  - load_start takes priority over run_start when both are high.
- Accepting load_start (from IDLE or RUN):
  - load_len=0 -> load_done pulses next cycle, then the FSM goes to RUN.
  - load_len>SIZE -> load_error=1, the FSM goes to IDLE, and no write occurs.
  - Otherwise the counter is cleared to 0, len is latched, and the FSM goes to WAIT_WORD.
- WAIT_WORD:
  - rx_ready=1.
  - On rx_valid&&rx_ready, data_reg<=rx_data and addr_reg<=counter, then -> SETUP.
  - rx_valid low means the FSM waits indefinitely.
- SETUP: ram_address=addr_reg, ram_data_in=data_reg, ram_write=0. Next state is STROBE.
- STROBE: same address and data, ram_write=1. Next state is HOLD. TextRAM captures the word on the write rising edge.
- HOLD:
  - Address and data are still held; ram_write=0.
  - Counter increments.
  - If counter+1==len: load_done=1 and -> RUN. Otherwise -> WAIT_WORD.
- Write timing and throughput:
  - Address and data are stable for one full cycle before and after the write pulse.
  - Maximum throughput is one word per 4 cycles.
- RUN:
  - cpu_stall=0, ram_write=0, ram_address=cpu_address combinationally, cpu_data=ram_data_out.
  - load_start re-enters the load flow, and cpu_stall=1 from the next cycle.
- Throughout every load state: cpu_stall=1 and rx_ready=0 except in WAIT_WORD.
- Ignored inputs:
  - load_start and run_start are ignored in WAIT_WORD, SETUP, STROBE and HOLD.
  - run_start is ignored in RUN.
- Address range: addresses never wrap, because len<=SIZE limits the last address to SIZE-1. len==SIZE writes every location.
- ram_data_in holds data_reg in all states, so it is stable and free of glitches.

Test Plan:
- Reset, then load_start with load_len=3 and words 0xA1, 0xB2, 0xC3 presented back-to-back:
  - ram_write is high exactly 3 cycles, at addresses 0, 1, 2.
  - load_done pulses once, 12 cycles after the first accept.
  - Afterwards cpu_stall=0, and cpu_address=1 gives cpu_data=0xB2.
- rx_valid deasserted for 5 cycles between words: the FSM stays in WAIT_WORD with ram_write=0, and the image is still correct at addresses 0..N-1.
- load_len=SIZE+1 (257): load_error=1, no ram_write, FSM in IDLE with cpu_stall=1. A following load_start with len=1 clears load_error.
- load_len=0 then run_start: load_done pulses and RUN is entered. Separately, run_start from IDLE gives cpu_stall=0 next cycle with memory untouched.
- Assert reset in the STROBE cycle of word 2 of 4: the next cycle shows ram_write=0, IDLE, cpu_stall=1, rx_ready=0.
- Check write timing on every strobe: ram_address and ram_data_in are unchanged in the cycle before and the cycle after ram_write=1.
- In RUN with cpu_stall=0, pulse load_start with len=2: cpu_stall=1 from the next cycle, and the reloaded words are readable after RUN resumes.
